// File: rtl/frame_sched_pkg.sv
// Shared types and copy-length constants for the frame copy scheduler and the rect copy controller.
// Also provides a fallback for the DATA_ADDR_WIDTH define when the build does not supply one.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

package frame_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      COPY  = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   localparam int RECT_COUNT_DEF = 64;
   localparam int RECT_WORDS_DEF = 6;

   // One extra cycle covers the copy_start cycle, where the first RAM read is issued.
   function automatic int copy_cycles(input int words, input int count);
      return words * count + 1;
   endfunction

   localparam int COPY_CYCLES_DEF = copy_cycles(RECT_WORDS_DEF, RECT_COUNT_DEF);

endpackage

// File: rtl/frame_copy_scheduler.sv
// Per-frame rect DMA sequencer and CPU/DMA arbiter for the data memory port.
// Optional macro FRAME_SCHED_GATE_EN: copy only frames the CPU has flagged with cpu_frame_ready.
//
// state | meaning
// IDLE  | CPU owns the port, waiting for frame_start
// STALL | CPU held, waiting for cpu_stall_ack
// COPY  | DMA owns the port for COPY_CYCLES cycles
// DONE  | one-cycle frame_done, port back on the CPU
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

module frame_copy_scheduler
   import frame_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = `DATA_ADDR_WIDTH,
   parameter int RECT_COUNT  = RECT_COUNT_DEF,
   parameter int RECT_WORDS  = RECT_WORDS_DEF,
   parameter int COPY_CYCLES = RECT_WORDS * RECT_COUNT + 1,
   parameter int CNT_WIDTH   = $clog2(COPY_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  cpu_stall_ack,
`ifdef FRAME_SCHED_GATE_EN
   input  logic                  cpu_frame_ready,
`endif
   input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
   input  logic                  cpu_mem_we,
   input  logic [ADDR_WIDTH-1:0] dma_mem_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  cpu_stall,
   output logic                  copy_start,
   output logic                  copy_busy,
   output logic                  frame_done,
   output logic                  overrun
);

   sched_state_t         state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 sel_dma;
   logic                 cpu_we_en;
   logic                 start_ok;

`ifdef FRAME_SCHED_GATE_EN
   logic pending;

   // Set wins over the clear on COPY entry so a ready pulse is never lost.
   always_ff @(posedge clk) begin
      if (reset)
         pending <= 1'b0;
      else if (cpu_frame_ready)
         pending <= 1'b1;
      else if (state == STALL && cpu_stall_ack)
         pending <= 1'b0;
   end

   assign start_ok = pending;
`else
   assign start_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         cpu_stall  <= 1'b0;
         copy_start <= 1'b0;
         copy_busy  <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         sel_dma    <= 1'b0;
         cpu_we_en  <= 1'b1;
      end else begin
         if (frame_start && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_start && start_ok) begin
                  state     <= STALL;
                  cpu_stall <= 1'b1;
               end
            end
            STALL: begin
               if (cpu_stall_ack) begin
                  state      <= COPY;
                  cnt        <= CNT_WIDTH'(COPY_CYCLES - 1);
                  copy_start <= 1'b1;
                  copy_busy  <= 1'b1;
                  sel_dma    <= 1'b1;
                  cpu_we_en  <= 1'b0;
               end
            end
            COPY: begin
               copy_start <= 1'b0;
               if (cnt == '0) begin
                  state      <= DONE;
                  copy_busy  <= 1'b0;
                  sel_dma    <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               frame_done <= 1'b0;
               cpu_stall  <= 1'b0;
               cpu_we_en  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_addr = sel_dma ? dma_mem_addr : cpu_mem_addr;
   assign mem_we   = cpu_we_en & cpu_mem_we;

endmodule

// File: tb/tb_frame_copy_scheduler.sv
// Self-checking bench for frame_copy_scheduler: phase-schedule reference model, randomized port traffic.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

module tb_frame_copy_scheduler;
   import frame_sched_pkg::*;

   localparam int AW     = `DATA_ADDR_WIDTH;
   localparam int NCOPY  = RECT_WORDS_DEF * RECT_COUNT_DEF + 1;
   localparam int P_IDLE = 0, P_STALL = 1, P_COPY = 2, P_DONE = 3;

   logic          clk = 1'b0;
   logic          reset, frame_start, cpu_stall_ack, cpu_mem_we, cpu_frame_ready;
   logic [AW-1:0] cpu_mem_addr, dma_mem_addr, mem_addr;
   logic          mem_we, cpu_stall, copy_start, copy_busy, frame_done, overrun;

   int total = 0;
   int bad   = 0;
   bit ov_m  = 1'b0;
   bit pend_m = 1'b0;

   always #5 clk = ~clk;

   frame_copy_scheduler dut (
      .clk(clk),
      .reset(reset),
      .frame_start(frame_start),
      .cpu_stall_ack(cpu_stall_ack),
`ifdef FRAME_SCHED_GATE_EN
      .cpu_frame_ready(cpu_frame_ready),
`endif
      .cpu_mem_addr(cpu_mem_addr),
      .cpu_mem_we(cpu_mem_we),
      .dma_mem_addr(dma_mem_addr),
      .mem_addr(mem_addr),
      .mem_we(mem_we),
      .cpu_stall(cpu_stall),
      .copy_start(copy_start),
      .copy_busy(copy_busy),
      .frame_done(frame_done),
      .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive inputs at negedge, then check outputs for the phase the DUT is known to be in.
   task automatic step(input int ph, input logic fs, input logic ack, input logic first, input logic rdy);
      @(negedge clk);
      frame_start     = fs;
      cpu_stall_ack   = ack;
      cpu_frame_ready = rdy;
      cpu_mem_addr    = AW'($urandom);
      cpu_mem_we      = 1'($urandom);
      dma_mem_addr    = AW'($urandom);
      #1;
      chk("cpu_stall",  32'(cpu_stall),  32'(ph != P_IDLE));
      chk("copy_busy",  32'(copy_busy),  32'(ph == P_COPY));
      chk("copy_start", 32'(copy_start), 32'(ph == P_COPY && first));
      chk("frame_done", 32'(frame_done), 32'(ph == P_DONE));
      chk("overrun",    32'(overrun),    32'(ov_m));
      chk("mem_addr",   32'(mem_addr),   32'((ph == P_COPY) ? dma_mem_addr : cpu_mem_addr));
      chk("mem_we",     32'(mem_we),     32'((ph == P_IDLE || ph == P_STALL) ? cpu_mem_we : 1'b0));
      if (fs && ph != P_IDLE) ov_m = 1'b1;
      if (rdy) pend_m = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      frame_start = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
      chk("rst_copy_busy",  32'(copy_busy),  32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_overrun",    32'(overrun),    32'd0);
      chk("rst_mem_addr",   32'(mem_addr),   32'(cpu_mem_addr));
      @(negedge clk);
      reset  = 1'b0;
      ov_m   = 1'b0;
      pend_m = 1'b0;
   endtask

   // d: STALL length (ack on its last cycle), ov_at: COPY cycle carrying a stray frame_start,
   // stall_fs: stray frame_start in STALL, done_fs: stray frame_start in DONE, abort_at: reset at that COPY cycle.
   task automatic run_frame(input int d, input int ov_at, input bit stall_fs, input bit done_fs, input int abort_at);
      int n;
      n = (d < 1) ? 1 : d;
`ifdef FRAME_SCHED_GATE_EN
      step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      step(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < n; k++)
         step(P_STALL, stall_fs && k == 0, (k == n - 1), 1'b0, 1'b0);
      pend_m = 1'b0;
      for (int k = 0; k < NCOPY; k++) begin
         if (k == abort_at) begin
            do_reset();
            step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         step(P_COPY, (k == ov_at), 1'($urandom), (k == 0), 1'b0);
      end
      step(P_DONE, done_fs, 1'b0, 1'b0, 1'b0);
      step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; cpu_stall_ack = 1'b0; cpu_frame_ready = 1'b0;
      cpu_mem_addr = '0; cpu_mem_we = 1'b0; dma_mem_addr = '0;
      repeat (3) @(posedge clk);
      do_reset();

      // CPU passthrough right after reset
      @(negedge clk);
      cpu_mem_addr = AW'(16'h0123);
      cpu_mem_we   = 1'b1;
      #1;
      chk("idle_addr",    32'(mem_addr),  32'h0123);
      chk("idle_we",      32'(mem_we),    32'd1);
      chk("idle_stall",   32'(cpu_stall), 32'd0);
      chk("idle_overrun", 32'(overrun),   32'd0);

      run_frame(0, -1, 1'b0, 1'b0, -1);    // ack already high: single STALL cycle
      run_frame(10, -1, 1'b0, 1'b0, -1);   // ack withheld 10 cycles
      run_frame(3, 100, 1'b0, 1'b0, -1);   // stray frame_start mid-copy
      run_frame(1, -1, 1'b0, 1'b0, 200);   // reset mid-copy
      run_frame(2, -1, 1'b0, 1'b1, -1);    // frame_start on the DONE->IDLE edge
      do_reset();
      run_frame(4, -1, 1'b1, 1'b0, -1);    // frame_start during STALL
      do_reset();
      for (int i = 0; i < 3; i++)
         run_frame(int'($urandom_range(0, 8)), int'($urandom_range(0, NCOPY + 50)), 1'b0,
                   1'($urandom), -1);

`ifdef FRAME_SCHED_GATE_EN
      do_reset();
      step(P_IDLE, 1'b1, 1'b1, 1'b0, 1'b0);   // no ready pulse: skipped
      step(P_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(1, -1, 1'b0, 1'b0, -1);
      step(P_IDLE, 1'b1, 1'b1, 1'b0, 1'b0);   // ready consumed: skipped again
      step(P_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
